// File: rtl/mem_check_initiator.sv
// -----------------------------------------------------------------------------
// mem_check_initiator
//
// Built-in self-check master for a single-port synchronous memory (write
// enable / address / write data, registered read data with one cycle of
// latency). When started, it writes a seed-derived pattern over an inclusive
// address range. It then reads the same range back and compares every word.
// At the end it reports pass/fail, a saturating mismatch count and the
// address of the first mismatch.
//
// Pattern: expected(a) = seed ^ zero_extend(a), computed at DATA_W bits.
//
// Optional build macro MEM_CHECK_INV_PASS_EN:
//   defined   - after the first write/read pass, a second pass runs with the
//               inverted pattern ~expected(a). Errors from both passes
//               accumulate into the same counter and first-error address.
//   undefined - a single pass only.
//
// Ports:
//   clk_i            in   clock, rising edge
//   srst_i           in   synchronous active-high reset
//   start_i          in   start pulse, only honoured while idle
//   start_addr_i     in   first address of the range (latched at start)
//   end_addr_i       in   last address of the range, inclusive (latched)
//   seed_i           in   pattern seed (latched at start)
//   mem_we_o         out  memory write enable (registered)
//   mem_addr_o       out  memory address (registered)
//   mem_wdata_o      out  memory write data (registered)
//   mem_rdata_i      in   memory read data, one cycle after address sample
//   busy_o           out  high while a check is in progress
//   done_o           out  one-cycle completion pulse
//   pass_o           out  1 = last run had no mismatches (held until start)
//   err_count_o      out  mismatch count of the last run, saturating
//   first_err_addr_o out  address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module mem_check_initiator #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;

    // Run configuration, captured when a start is accepted.
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [DATA_W-1:0] seed_q;

    // Compare stage: expected word and address of the read issued last cycle.
    logic              vld_p1;
    logic [ADDR_W-1:0] cmp_addr_p1;
    logic [DATA_W-1:0] cmp_exp_p1;

    logic              first_err_seen;
    logic              cur_inv;
    logic [ADDR_W-1:0] addr_inc;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;
    logic              accept;

    // Pattern generator. inv selects the inverted pattern of the second pass.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [DATA_W-1:0] seed,
        input logic [ADDR_W-1:0] addr,
        input logic              inv
    );
        logic [DATA_W-1:0] p;
        p = seed ^ DATA_W'(addr);
        return inv ? ~p : p;
    endfunction

    // Saturating increment of the error counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

`ifdef MEM_CHECK_INV_PASS_EN
    logic inv_q;
    assign cur_inv = inv_q;
`else
    assign cur_inv = 1'b0;
`endif

    assign accept   = (state == S_IDLE) && start_i;
    assign addr_inc = mem_addr_o + ADDR_W'(1);
    assign mismatch = vld_p1 && (mem_rdata_i != cmp_exp_p1);
    assign err_next = mismatch ? sat_inc(err_count_o) : err_count_o;

    // ---- stage p0: configuration latch and read-issue capture ----
    // Data-only registers. They are not reset because they are always written
    // before use: the configuration is latched at start, and the compare
    // payload is qualified by vld_p1.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            start_q <= start_addr_i;
            end_q   <= end_addr_i;
            seed_q  <= seed_i;
        end
        if (state == S_READ) begin
            cmp_addr_p1 <= mem_addr_o;
            cmp_exp_p1  <= pattern(seed_q, mem_addr_o, cur_inv);
        end
    end

    // ---- stage p1: control FSM, memory drive and result compare ----
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state            <= S_IDLE;
            vld_p1           <= 1'b0;
            first_err_seen   <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
`ifdef MEM_CHECK_INV_PASS_EN
            inv_q            <= 1'b0;
`endif
        end else begin
            vld_p1 <= 1'b0;
            done_o <= 1'b0;

            // Compare the word returned for the previous read. This is done
            // in READ and in the DRAIN cycle that follows the last read.
            if (mismatch) begin
                err_count_o <= err_next;
                if (!first_err_seen) begin
                    first_err_seen   <= 1'b1;
                    first_err_addr_o <= cmp_addr_p1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        err_count_o      <= '0;
                        first_err_addr_o <= '0;
                        first_err_seen   <= 1'b0;
                        pass_o           <= 1'b0;
                        busy_o           <= 1'b1;
                        if (end_addr_i < start_addr_i) begin
                            // Empty range: skip all memory traffic. DRAIN
                            // makes no compare (vld_p1 is clear) and
                            // finishes one cycle later.
                            state <= S_DRAIN;
`ifdef MEM_CHECK_INV_PASS_EN
                            inv_q <= 1'b1;
`endif
                        end else begin
                            state       <= S_WRITE;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= start_addr_i;
                            mem_wdata_o <= pattern(seed_i, start_addr_i, 1'b0);
`ifdef MEM_CHECK_INV_PASS_EN
                            inv_q       <= 1'b0;
`endif
                        end
                    end
                end

                S_WRITE: begin
                    // Terminate by equality with end, so an end of all-ones
                    // never needs the counter to wrap.
                    if (mem_addr_o == end_q) begin
                        state      <= S_READ;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= start_q;
                    end else begin
                        mem_addr_o  <= addr_inc;
                        mem_wdata_o <= pattern(seed_q, addr_inc, cur_inv);
                    end
                end

                S_READ: begin
                    vld_p1 <= 1'b1;
                    if (mem_addr_o == end_q) begin
                        state <= S_DRAIN;
                    end else begin
                        mem_addr_o <= addr_inc;
                    end
                end

                S_DRAIN: begin
`ifdef MEM_CHECK_INV_PASS_EN
                    if (!inv_q) begin
                        // Start the inverted-pattern pass right after the
                        // final compare of the first pass.
                        inv_q       <= 1'b1;
                        state       <= S_WRITE;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= start_q;
                        mem_wdata_o <= pattern(seed_q, start_q, 1'b1);
                    end else begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_next == '0);
                    end
`else
                    // err_next includes the compare made in this cycle.
                    state  <= S_DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= (err_next == '0);
`endif
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    mem_we_o <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_check_initiator.sv
// -----------------------------------------------------------------------------
// Directed testbench for mem_check_initiator. Two instances are used: one with
// default parameters and one with ERR_W=2 for counter saturation. Each
// instance has a small behavioural memory model that can corrupt read data.
// -----------------------------------------------------------------------------
module tb_mem_check_initiator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic        start;
    logic        start_s;
    logic [15:0] sa;
    logic [15:0] ea;
    logic [31:0] seed;

    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] errc;
    logic [15:0] ferr;

    logic        we_s;
    logic [15:0] addr_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;
    logic        busy_s;
    logic        done_s;
    logic        pass_s;
    logic [1:0]  errc_s;
    logic [15:0] ferr_s;

    int checks = 0;
    int errors = 0;

    mem_check_initiator dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .start_i          (start),
        .start_addr_i     (sa),
        .end_addr_i       (ea),
        .seed_i           (seed),
        .mem_we_o         (we),
        .mem_addr_o       (addr),
        .mem_wdata_o      (wdata),
        .mem_rdata_i      (rdata),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (errc),
        .first_err_addr_o (ferr)
    );

    mem_check_initiator #(.ERR_W(2)) dut_sat (
        .clk_i            (clk),
        .srst_i           (srst),
        .start_i          (start_s),
        .start_addr_i     (sa),
        .end_addr_i       (ea),
        .seed_i           (seed),
        .mem_we_o         (we_s),
        .mem_addr_o       (addr_s),
        .mem_wdata_o      (wdata_s),
        .mem_rdata_i      (rdata_s),
        .busy_o           (busy_s),
        .done_o           (done_s),
        .pass_o           (pass_s),
        .err_count_o      (errc_s),
        .first_err_addr_o (ferr_s)
    );

    // Behavioural memories: 256 words, indexed by the low address byte.
    logic [31:0] mem   [256];
    logic [31:0] mem_s [256];
    logic        corrupt_en    = 1'b0;
    logic [15:0] corrupt_addr  = 16'h0;
    logic        corrupt_all_s = 1'b0;
    int          wr_cnt   = 0;
    int          wrap_cnt = 0;

    always @(posedge clk) begin
        if (we) begin
            mem[addr[7:0]] <= wdata;
            wr_cnt <= wr_cnt + 1;
        end
        rdata <= mem[addr[7:0]] ^ ((corrupt_en && addr == corrupt_addr) ? 32'h1 : 32'h0);
        if (busy && addr == 16'h0000) wrap_cnt <= wrap_cnt + 1;
    end

    always @(posedge clk) begin
        if (we_s) mem_s[addr_s[7:0]] <= wdata_s;
        rdata_s <= mem_s[addr_s[7:0]] ^ (corrupt_all_s ? 32'h8000_0000 : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start on the main instance. Returns in the cycle after edge 0.
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; cyc counts cycles after edge 0.
    task automatic wait_done(input bit sat, output int cyc);
        cyc = 0;
        while (((sat ? done_s : done) !== 1'b1) && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int wr0;
    int wrap0;

    initial begin
        srst  = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        sa    = 16'h0;
        ea    = 16'h0;
        seed  = 32'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_we",    {31'b0, we},   32'h0);
        chk("rst_addr",  {16'b0, addr}, 32'h0);
        chk("rst_wdata", wdata,         32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        chk("rst_done",  {31'b0, done}, 32'h0);
        chk("rst_pass",  {31'b0, pass}, 32'h0);
        chk("rst_errc",  {16'b0, errc}, 32'h0);
        chk("rst_ferr",  {16'b0, ferr}, 32'h0);
        chk("rst_s_errc", {30'b0, errc_s}, 32'h0);
        chk("rst_s_we",  {31'b0, we_s}, 32'h0);
        srst = 1'b0;
        tick();

        // Clean run 0x0010..0x0013, cycle-accurate
        sa = 16'h0010; ea = 16'h0013; seed = 32'hA5A5_0000;
        go();
        for (int k = 0; k < 4; k++) begin
            chk("clean_wr_we",    {31'b0, we},   32'h1);
            chk("clean_wr_addr",  {16'b0, addr}, 32'h0010 + k);
            chk("clean_wr_wdata", wdata,         32'hA5A5_0010 + k);
            chk("clean_wr_busy",  {31'b0, busy}, 32'h1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("clean_rd_we",   {31'b0, we},   32'h0);
            chk("clean_rd_addr", {16'b0, addr}, 32'h0010 + k);
            tick();
        end
        chk("clean_drain_we",   {31'b0, we},   32'h0);
        chk("clean_drain_done", {31'b0, done}, 32'h0);
        chk("clean_drain_busy", {31'b0, busy}, 32'h1);
        tick();
        chk("clean_done", {31'b0, done}, 32'h1);
        chk("clean_busy", {31'b0, busy}, 32'h0);
        chk("clean_pass", {31'b0, pass}, 32'h1);
        chk("clean_errc", {16'b0, errc}, 32'h0);
        chk("clean_ferr", {16'b0, ferr}, 32'h0);
        tick();
        chk("clean_done_pulse", {31'b0, done}, 32'h0);
        chk("clean_pass_held",  {31'b0, pass}, 32'h1);

        // Forced mismatch at 0x0012
        corrupt_en = 1'b1; corrupt_addr = 16'h0012;
        go();
        chk("mm_pass_cleared", {31'b0, pass}, 32'h0);
        wait_done(1'b0, cyc);
        chk("mm_latency", cyc, 32'd9);
        chk("mm_pass", {31'b0, pass}, 32'h0);
        chk("mm_errc", {16'b0, errc}, 32'h1);
        chk("mm_ferr", {16'b0, ferr}, 32'h0012);
        corrupt_en = 1'b0;
        tick();

        // Empty range
        sa = 16'h0005; ea = 16'h0004;
        wr0 = wr_cnt;
        go();
        chk("empty_we",   {31'b0, we},   32'h0);
        chk("empty_busy", {31'b0, busy}, 32'h1);
        chk("empty_done_early", {31'b0, done}, 32'h0);
        tick();
        chk("empty_done", {31'b0, done}, 32'h1);
        chk("empty_pass", {31'b0, pass}, 32'h1);
        chk("empty_errc", {16'b0, errc}, 32'h0);
        chk("empty_writes", wr_cnt - wr0, 32'd0);
        tick();

        // Reset in the middle of WRITE (N=8), then a fresh run
        sa = 16'h0020; ea = 16'h0027; seed = 32'h1234_5678;
        go();
        tick();
        chk("mid_we_before", {31'b0, we}, 32'h1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mid_rst_we",    {31'b0, we},   32'h0);
        chk("mid_rst_addr",  {16'b0, addr}, 32'h0);
        chk("mid_rst_wdata", wdata,         32'h0);
        chk("mid_rst_busy",  {31'b0, busy}, 32'h0);
        chk("mid_rst_pass",  {31'b0, pass}, 32'h0);
        chk("mid_rst_done",  {31'b0, done}, 32'h0);
        tick();
        chk("mid_rst_we_quiet", {31'b0, we}, 32'h0);
        go();
        wait_done(1'b0, cyc);
        chk("mid_rerun_latency", cyc, 32'd17);
        chk("mid_rerun_pass", {31'b0, pass}, 32'h1);
        chk("mid_rerun_errc", {16'b0, errc}, 32'h0);
        tick();

        // Top-of-space range with a start pulse while busy
        sa = 16'hFFFE; ea = 16'hFFFF; seed = 32'h0F0F_0000;
        wr0 = wr_cnt; wrap0 = wrap_cnt;
        go();
        chk("top_w0_addr",  {16'b0, addr}, 32'hFFFE);
        chk("top_w0_wdata", wdata,         32'h0F0F_FFFE);
        start = 1'b1; sa = 16'h0000; ea = 16'h0003;
        tick();
        start = 1'b0;
        chk("top_w1_we",    {31'b0, we},   32'h1);
        chk("top_w1_addr",  {16'b0, addr}, 32'hFFFF);
        chk("top_w1_wdata", wdata,         32'h0F0F_FFFF);
        tick();
        chk("top_r0_we",   {31'b0, we},   32'h0);
        chk("top_r0_addr", {16'b0, addr}, 32'hFFFE);
        tick();
        chk("top_r1_addr", {16'b0, addr}, 32'hFFFF);
        tick();
        chk("top_drain_we", {31'b0, we}, 32'h0);
        tick();
        chk("top_done",   {31'b0, done}, 32'h1);
        chk("top_pass",   {31'b0, pass}, 32'h1);
        chk("top_writes", wr_cnt - wr0, 32'd2);
        chk("top_nowrap", wrap_cnt - wrap0, 32'd0);
        tick();
        chk("top_idle_we", {31'b0, we}, 32'h0);

        // Saturation with ERR_W=2: all 5 words corrupted
        sa = 16'h0030; ea = 16'h0034; seed = 32'hDEAD_0000;
        corrupt_all_s = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        wait_done(1'b1, cyc);
        chk("sat_latency", cyc, 32'd11);
        chk("sat_errc", {30'b0, errc_s}, 32'h3);
        chk("sat_ferr", {16'b0, ferr_s}, 32'h0030);
        chk("sat_pass", {31'b0, pass_s}, 32'h0);
        corrupt_all_s = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
